stdp_array: RTL and testbench

Parametrised pair-based STDP learning block for N synapses converging on one post-synaptic neuron. It tracks per-synapse pre-spike age and a shared post-spike age, and applies potentiation (LTP) on post spikes and depression (LTD) on pre spikes. Each update uses a shift-based exponential kernel with saturating weight arithmetic. It sits between the spike sources and the neuron's weighted-sum stage and supersedes the single-synapse LTP-only learner.

---
 rtl/stdp_pkg.sv | 32 +++
 rtl/stdp_kernel.sv | 23 ++
 rtl/stdp_array.sv | 133 +++++++++++++
 tb/tb_stdp_array.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/stdp_pkg.sv
// Shared constants, typedefs and saturating arithmetic for the STDP learner.
// Build option STDP_LTD_EN (see stdp_array) enables the depression path.
package stdp_pkg;

  localparam int N_DEF         = 4;
  localparam int W_W_DEF       = 8;
  localparam int TIMER_W_DEF   = 8;
  localparam int W_INIT_DEF    = 64;
  localparam int W_MAX_DEF     = 255;
  localparam int A_PLUS_DEF    = 16;
  localparam int A_MINUS_DEF   = 8;
  localparam int TAU_SHIFT_DEF = 2;
  localparam int WINDOW_DEF    = 32;

  typedef logic [W_W_DEF-1:0]     weight_t;
  typedef logic [TIMER_W_DEF-1:0] age_t;

  // Operands are zero-extended into 32 bits, so the sum can never wrap.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max_v);
    logic [31:0] s;
    s = a + b;
    return (s > max_v) ? max_v : s;
  endfunction

  function automatic logic [31:0] sat_sub(input logic [31:0] a,
                                          input logic [31:0] b);
    return (a > b) ? (a - b) : 32'd0;
  endfunction

endpackage

// File: rtl/stdp_kernel.sv
// Combinational shift-based exponential STDP kernel with plasticity window check.
// Used for both LTP and LTD (one instance per synapse per direction).
module stdp_kernel
  import stdp_pkg::*;
#(
  parameter int TIMER_W   = TIMER_W_DEF,
  parameter int W_W       = W_W_DEF,
  parameter int TAU_SHIFT = TAU_SHIFT_DEF,
  parameter int WINDOW    = WINDOW_DEF
) (
  input  logic               valid,
  input  logic [TIMER_W:0]   dt,
  input  logic [W_W-1:0]     amp,
  output logic [W_W-1:0]     delta,
  output logic               hit
);

  localparam logic [TIMER_W:0] WIN = (TIMER_W+1)'(WINDOW);

  assign hit   = valid && (dt < WIN);
  assign delta = amp >> (dt >> TAU_SHIFT);

endmodule

// File: rtl/stdp_array.sv
// Pair-based STDP learner for N synapses on one post-synaptic neuron.
// Define STDP_LTD_EN to compile in depression (LTD); otherwise LTP-only.
module stdp_array
  import stdp_pkg::*;
#(
  parameter int N         = N_DEF,
  parameter int W_W       = W_W_DEF,
  parameter int TIMER_W   = TIMER_W_DEF,
  parameter int W_INIT    = W_INIT_DEF,
  parameter int W_MAX     = W_MAX_DEF,
  parameter int A_PLUS    = A_PLUS_DEF,
  parameter int A_MINUS   = A_MINUS_DEF,
  parameter int TAU_SHIFT = TAU_SHIFT_DEF,
  parameter int WINDOW    = WINDOW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 learn_en,
  input  logic [N-1:0]         pre_spike,
  input  logic                 post_spike,
  input  logic                 wr_en,
  input  logic [$clog2(N)-1:0] wr_idx,
  input  logic [W_W-1:0]       wr_data,
  output logic [N*W_W-1:0]     weights,
  output logic [N-1:0]         ltp_flag,
  output logic [N-1:0]         ltd_flag
);

  localparam logic [W_W-1:0]     WMAX   = W_W'(W_MAX);
  localparam logic [W_W-1:0]     WINIT  = W_W'(W_INIT);
  localparam logic [W_W-1:0]     AP     = W_W'(A_PLUS);
  localparam logic [TIMER_W-1:0] AGE_SAT = '1;
  localparam logic [TIMER_W:0]   DT_ONE = (TIMER_W+1)'(1);

  logic [TIMER_W-1:0] pre_age [N];
  logic [W_W-1:0]     w_q     [N];
  logic [W_W-1:0]     ltp_delta [N];
  logic [N-1:0]       ltp_hit;
  logic [N-1:0]       ltp_q;
  logic [W_W-1:0]     wr_clamped;

  assign wr_clamped = (wr_data > WMAX) ? WMAX : wr_data;

`ifdef STDP_LTD_EN
  localparam logic [W_W-1:0] AM = W_W'(A_MINUS);

  logic [TIMER_W-1:0] post_age;
  logic [TIMER_W:0]   ltd_dt;
  logic [W_W-1:0]     ltd_delta [N];
  logic [N-1:0]       ltd_hit;
  logic [N-1:0]       ltd_q;

  // Only a pre spike without a coincident post can depress; coincidence is LTP.
  assign ltd_dt   = {1'b0, post_age} + DT_ONE;
  assign ltd_flag = ltd_q;
`else
  logic [31:0] unused_a_minus;
  assign unused_a_minus = 32'(A_MINUS);
  assign ltd_flag       = '0;
`endif

  assign ltp_flag = ltp_q;

  for (genvar g = 0; g < N; g++) begin : g_syn
    logic [TIMER_W:0] ltp_dt;
    logic             ltp_valid;

    assign ltp_dt    = pre_spike[g] ? '0 : ({1'b0, pre_age[g]} + DT_ONE);
    assign ltp_valid = post_spike && (pre_spike[g] || (pre_age[g] != AGE_SAT));

    stdp_kernel #(
      .TIMER_W(TIMER_W), .W_W(W_W), .TAU_SHIFT(TAU_SHIFT), .WINDOW(WINDOW)
    ) u_ltp (
      .valid(ltp_valid), .dt(ltp_dt), .amp(AP),
      .delta(ltp_delta[g]), .hit(ltp_hit[g])
    );

`ifdef STDP_LTD_EN
    logic ltd_valid;
    assign ltd_valid = pre_spike[g] && !post_spike && (post_age != AGE_SAT);

    stdp_kernel #(
      .TIMER_W(TIMER_W), .W_W(W_W), .TAU_SHIFT(TAU_SHIFT), .WINDOW(WINDOW)
    ) u_ltd (
      .valid(ltd_valid), .dt(ltd_dt), .amp(AM),
      .delta(ltd_delta[g]), .hit(ltd_hit[g])
    );
`endif

    assign weights[g*W_W +: W_W] = w_q[g];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        w_q[i]     <= WINIT;
        pre_age[i] <= AGE_SAT;
      end
      ltp_q <= '0;
`ifdef STDP_LTD_EN
      post_age <= AGE_SAT;
      ltd_q    <= '0;
`endif
    end else begin
`ifdef STDP_LTD_EN
      post_age <= post_spike ? '0 :
                  ((post_age == AGE_SAT) ? AGE_SAT : post_age + TIMER_W'(1));
`endif
      for (int i = 0; i < N; i++) begin
        pre_age[i] <= pre_spike[i] ? '0 :
                      ((pre_age[i] == AGE_SAT) ? AGE_SAT : pre_age[i] + TIMER_W'(1));
        ltp_q[i] <= 1'b0;
`ifdef STDP_LTD_EN
        ltd_q[i] <= 1'b0;
`endif
        // A host write overrides any learning update on the same synapse.
        if (wr_en && (32'(wr_idx) == i)) begin
          w_q[i] <= wr_clamped;
        end else if (learn_en && ltp_hit[i]) begin
          w_q[i]   <= W_W'(sat_add(32'(w_q[i]), 32'(ltp_delta[i]), 32'(WMAX)));
          ltp_q[i] <= 1'b1;
        end
`ifdef STDP_LTD_EN
        else if (learn_en && ltd_hit[i]) begin
          w_q[i]   <= W_W'(sat_sub(32'(w_q[i]), 32'(ltd_delta[i])));
          ltd_q[i] <= 1'b1;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_stdp_array.sv
// Directed bench for stdp_array with default parameters; expectations are
// hand-computed and follow STDP_LTD_EN when it is defined for the build.
module tb_stdp_array;

  localparam int N   = 4;
  localparam int W_W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           learn_en;
  logic [N-1:0]   pre_spike;
  logic           post_spike;
  logic           wr_en;
  logic [1:0]     wr_idx;
  logic [W_W-1:0] wr_data;
  logic [N*W_W-1:0] weights;
  logic [N-1:0]   ltp_flag;
  logic [N-1:0]   ltd_flag;

  int n_assert = 0;
  int n_fail   = 0;

  stdp_array dut (
    .clk(clk), .rst(rst), .learn_en(learn_en), .pre_spike(pre_spike),
    .post_spike(post_spike), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .weights(weights), .ltp_flag(ltp_flag), .ltd_flag(ltd_flag)
  );

  always #5 clk = ~clk;

  function automatic logic [W_W-1:0] wt(input int i);
    return weights[i*W_W +: W_W];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock with the given spikes; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input logic [N-1:0] p, input logic q);
    pre_spike  = p;
    post_spike = q;
    @(posedge clk);
    #1;
    pre_spike  = '0;
    post_spike = 1'b0;
    wr_en      = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc('0, 1'b0);
  endtask

  task automatic write(input logic [1:0] idx, input logic [W_W-1:0] d);
    wr_en   = 1'b1;
    wr_idx  = idx;
    wr_data = d;
    cyc('0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; learn_en = 1'b1; pre_spike = '0; post_spike = 1'b0;
    wr_en = 1'b0; wr_idx = '0; wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < N; i++) chk($sformatf("reset_w%0d", i), wt(i), 64);
    chk("reset_ltp_flag", ltp_flag, 0);
    chk("reset_ltd_flag", ltd_flag, 0);

    // Post with no pre ever seen
    cyc('0, 1'b1);
    chk("lone_post_weights", weights, {4{8'd64}});
    chk("lone_post_ltp_flag", ltp_flag, 0);
    idle(40);

    // pre[0] then post 3 cycles later: dt=3, delta 16
    cyc(4'b0001, 1'b0);
    idle(2);
    cyc('0, 1'b1);
    chk("ltp_dt3_w0", wt(0), 80);
    chk("ltp_dt3_flag", ltp_flag, 4'b0001);
    chk("ltp_dt3_others", weights[N*W_W-1:W_W], {3{8'd64}});
    idle(1);
    chk("ltp_flag_pulse", ltp_flag, 0);
    idle(40);

    // dt=9: delta 16>>2 = 4
    cyc(4'b0010, 1'b0);
    idle(8);
    cyc('0, 1'b1);
    chk("ltp_dt9_w1", wt(1), 68);
    chk("ltp_dt9_flag", ltp_flag, 4'b0010);
    idle(40);

    // dt=31: delta 16>>7 = 0, flag still raised
    cyc(4'b0010, 1'b0);
    idle(30);
    cyc('0, 1'b1);
    chk("ltp_dt31_w1", wt(1), 68);
    chk("ltp_dt31_flag", ltp_flag, 4'b0010);
    idle(40);

    // dt=32 = WINDOW: outside window
    cyc(4'b0010, 1'b0);
    idle(31);
    cyc('0, 1'b1);
    chk("ltp_dt32_w1", wt(1), 68);
    chk("ltp_dt32_flag", ltp_flag, 0);
    idle(40);

    // post then pre[2] 5 cycles later: dt=5, delta 8>>1 = 4
    cyc('0, 1'b1);
    idle(4);
    cyc(4'b0100, 1'b0);
`ifdef STDP_LTD_EN
    chk("ltd_dt5_w2", wt(2), 60);
    chk("ltd_dt5_flag", ltd_flag, 4'b0100);
`else
    chk("ltd_dt5_w2", wt(2), 64);
    chk("ltd_dt5_flag", ltd_flag, 0);
`endif
    chk("ltd_dt5_no_ltp", ltp_flag, 0);
    idle(40);

    // Upper clamp on synapse 3
    write(2'd3, 8'd250);
    chk("write_w3_250", wt(3), 250);
    cyc(4'b1000, 1'b0);
    cyc('0, 1'b1);
    chk("clamp_hi_w3", wt(3), 255);
    chk("clamp_hi_flag", ltp_flag, 4'b1000);
    idle(40);

    // Lower clamp on synapse 3
    write(2'd3, 8'd3);
    chk("write_w3_3", wt(3), 3);
    cyc('0, 1'b1);
    cyc(4'b1000, 1'b0);
`ifdef STDP_LTD_EN
    chk("clamp_lo_w3", wt(3), 0);
    chk("clamp_lo_flag", ltd_flag, 4'b1000);
`else
    chk("clamp_lo_w3", wt(3), 3);
    chk("clamp_lo_flag", ltd_flag, 0);
`endif
    idle(40);

    // Coincident pre and post: LTP only, dt=0
    cyc(4'b0001, 1'b1);
    chk("coinc_w0", wt(0), 96);
    chk("coinc_ltp_flag", ltp_flag, 4'b0001);
    chk("coinc_ltd_flag", ltd_flag, 0);
    idle(40);

    // Same with learning disabled
    learn_en = 1'b0;
    cyc(4'b0001, 1'b1);
    learn_en = 1'b1;
    chk("gated_w0", wt(0), 96);
    chk("gated_ltp_flag", ltp_flag, 0);
    idle(40);

    // Host write wins on synapse 0; synapse 1 still learns
    wr_en = 1'b1; wr_idx = 2'd0; wr_data = 8'd7;
    cyc(4'b0011, 1'b1);
    chk("wr_prio_w0", wt(0), 7);
    chk("wr_prio_w1", wt(1), 84);
    chk("wr_prio_flag", ltp_flag, 4'b0010);
    idle(40);

    // Reset right after a pre discards it
    cyc(4'b0100, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_reset_weights", weights, {4{8'd64}});
    cyc('0, 1'b1);
    chk("post_after_reset_w2", wt(2), 64);
    chk("post_after_reset_flag", ltp_flag, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
